hex_digit_counter: RTL
======================

Name: hex_digit_counter

Overview:
- Upstream feeder for the board's 4-bit hex-to-7-segment decoder.
- Produces one 4-bit hex digit that steps up or down at a selectable rate, derived from the board clock through an internal rate divider.
- Supports a synchronous parallel load.
- `digit` drives the decoder's 4-bit input directly. `tick` and `wrap` are available for cascading a second digit.

Parameters:
- CLK_FREQ, 50000000, base period in clock cycles for the 1 Hz setting; benches override with a small value (e.g. 4).
- CNT_W, 28, rate-divider counter width; must hold 4*CLK_FREQ-1.

Ports:
- CLOCK_50  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- enable  input  1  1 = count, 0 = freeze divider and digit
- speed  input  2  period select: 00 = every cycle, 01 = CLK_FREQ, 10 = 2*CLK_FREQ, 11 = 4*CLK_FREQ cycles
- up  input  1  1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_value  input  4  value loaded into digit
- digit  output  4  current hex digit (registered)
- tick  output  1  one-cycle pulse, high in the cycle digit shows a newly stepped value
- wrap  output  1  one-cycle pulse coincident with tick when the step wrapped F->0 (up) or 0->F (down)

Behaviour:
- Internal state:
  - rate_cnt[CNT_W-1:0]
  - speed_q[1:0], the last applied speed
  - digit, tick, wrap
- P(speed) is the selected period (1, CLK_FREQ, 2*CLK_FREQ, 4*CLK_FREQ). RELOAD = P(speed)-1, computed at CNT_W bits with no truncation.
- Reset (async, highest priority) sets digit=0, tick=0, wrap=0, rate_cnt=0, speed_q=00.
- Each rising edge, in strict priority order:
  1. load=1: digit<=load_value, rate_cnt<=RELOAD, speed_q<=speed, tick<=0, wrap<=0. Acts regardless of enable.
  2. speed!=speed_q: rate_cnt<=RELOAD, speed_q<=speed, digit holds, tick<=0, wrap<=0. Acts regardless of enable.
  3. enable=0: rate_cnt and digit hold, tick<=0, wrap<=0.
  4. enable=1 and rate_cnt!=0: rate_cnt<=rate_cnt-1, tick<=0, wrap<=0.
  5. enable=1 and rate_cnt==0 (advance):
     - digit<=digit+1 if up=1, else digit-1, modulo 16
     - rate_cnt<=RELOAD, tick<=1
     - wrap<=1 iff (up=1 and digit==F) or (up=0 and digit==0); otherwise wrap<=0
- Step rate: with steady speed and enable, digit steps exactly once every P enabled cycles.
  - speed=00 (P=1): rate_cnt stays 0, so digit steps and tick is high every cycle.
- Latency: tick and wrap are registered alongside digit. They go high in the same cycle digit first shows the new value and last exactly one cycle unless the next cycle also advances (speed=00).
- Disable and resume: enable low mid-count preserves rate_cnt. The remaining count resumes exactly where it stopped.
- First step after reset:
  - speed=00: steps on the first enabled cycle.
  - Any other speed: the first edge performs a speed-change reload (rule 2), then the digit steps after a further P enabled cycles.
- `up` is sampled only on advance cycles. Changing `up` mid-count does not reload the divider.
- `load_value` is ignored unless load=1.
- Load and advance in the same cycle: load wins, and no tick is produced.
- Reset asserted mid-count clears outputs asynchronously, without waiting for an edge.
- After reset deasserts, behaviour resumes per the rules above on the next edge.

Test Plan:
- Reset → digit=0, tick=0, wrap=0:
  - held at start, before any edge;
  - pulsed asynchronously between edges mid-count at digit=7 (outputs clear before the next edge).
- CLK_FREQ=4, speed=00, up=1, enable=1, from reset:
  - digit steps 1,2,...,F,0 on consecutive cycles with tick high every cycle;
  - wrap=1 only in the cycle digit shows 0 after F.
- CLK_FREQ=4, speed=01, enable=1:
  - after the reload edge, tick pulses every 4 cycles and digit 0→1→2;
  - switching to speed=11 mid-count reloads rate_cnt=15, giving no tick for the next 16 cycles, then a tick every 16.
- load=1 with load_value=A, up=0, speed=00, enable=1:
  - next cycle digit=A with tick=0;
  - then 9,8,...,0,F, with wrap=1 exactly when F appears.
- CLK_FREQ=4, speed=01:
  - drop enable for 10 cycles after 2 counts into a period; digit holds and tick stays 0;
  - re-raise enable; the tick occurs after exactly 2 more enabled cycles.
- load=1 in the same cycle as an advance (rate_cnt==0) with load_value=3 → digit=3, tick=0, and the next tick comes P cycles later.

Source files
------------

// File: rtl/hex_digit_counter.sv
// Single hex digit that steps up or down at a selectable rate, with parallel load.
// The tick and wrap pulses are registered with digit so a second digit can cascade from them.
module hex_digit_counter #(
    parameter int CLK_FREQ = 50000000,
    parameter int CNT_W    = 28
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] digit,
    output logic       tick,
    output logic       wrap
);

    logic [CNT_W-1:0] rate_cnt_q, rate_cnt_d;
    logic [CNT_W-1:0] base_period;
    logic [CNT_W-1:0] reload;
    logic [1:0]       speed_q, speed_d;
    logic [3:0]       digit_q, digit_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    // Reload is period-1, so speed 00 keeps the divider parked at zero and steps every cycle.
    assign base_period = CNT_W'(CLK_FREQ);

    always_comb begin
        reload = '0;
        case (speed)
            2'b00:   reload = '0;
            2'b01:   reload = base_period - CNT_W'(1);
            2'b10:   reload = (base_period << 1) - CNT_W'(1);
            default: reload = (base_period << 2) - CNT_W'(1);
        endcase
    end

    always_comb begin
        rate_cnt_d = rate_cnt_q;
        speed_d    = speed_q;
        digit_d    = digit_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        if (load) begin
            digit_d    = load_value;
            rate_cnt_d = reload;
            speed_d    = speed;
        end else if (speed != speed_q) begin
            rate_cnt_d = reload;
            speed_d    = speed;
        end else if (enable) begin
            if (rate_cnt_q != '0) begin
                rate_cnt_d = rate_cnt_q - CNT_W'(1);
            end else begin
                digit_d    = up ? digit_q + 4'd1 : digit_q - 4'd1;
                rate_cnt_d = reload;
                tick_d     = 1'b1;
                wrap_d     = up ? (digit_q == 4'hF) : (digit_q == 4'h0);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rate_cnt_q <= '0;
            speed_q    <= 2'b00;
            digit_q    <= 4'h0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            rate_cnt_q <= rate_cnt_d;
            speed_q    <= speed_d;
            digit_q    <= digit_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
        end
    end

    assign digit = digit_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule
